// File: rtl/hsem_lock_ctrl.sv
// hsem_lock_ctrl: two-core hardware semaphore lock engine with collision arbitration.
// Optional macro HSEM_PROCID_EN: ownership is (core, pid) instead of core only.
`ifndef SEMERR_WIDTH
`define SEMERR_WIDTH 32
`endif

module hsem_lock_ctrl #(
    parameter int SEM_NUM = 8,
    parameter int IDX_W   = 5,
    parameter int PID_W   = 8
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic                     req_vld_0,
    input  logic [1:0]               req_op_0,
    input  logic [IDX_W-1:0]         req_idx_0,
    input  logic [PID_W-1:0]         req_pid_0,
    input  logic                     req_vld_1,
    input  logic [1:0]               req_op_1,
    input  logic [IDX_W-1:0]         req_idx_1,
    input  logic [PID_W-1:0]         req_pid_1,
    output logic                     rsp_vld_0,
    output logic                     rsp_vld_1,
    output logic [31:0]              rsp_data_0,
    output logic [31:0]              rsp_data_1,
    output logic [`SEMERR_WIDTH-1:0] semerr_0,
    output logic [`SEMERR_WIDTH-1:0] semerr_1,
    output logic                     free_evt_0,
    output logic                     free_evt_1,
    output logic [SEM_NUM-1:0]       sem_lock
);
    localparam int ERR_W = `SEMERR_WIDTH;
    localparam int PV_W  = SEM_NUM * PID_W;

    typedef struct packed {
        logic [SEM_NUM-1:0] lock;
        logic [SEM_NUM-1:0] own;
        logic [PV_W-1:0]    pidv;
    } sem_state_t;

    typedef struct packed {
        logic [31:0]        rsp;
        logic [ERR_W-1:0]   err;
        logic [SEM_NUM-1:0] freed;
        logic [SEM_NUM-1:0] fail;
        logic [SEM_NUM-1:0] got;
    } serve_res_t;

    logic [SEM_NUM-1:0] lock_r, own_r, pend0_r, pend1_r;
    logic [PV_W-1:0]    pid_r;
    logic               ptr_r;
    logic [PID_W-1:0]   pid_in_0_s, pid_in_1_s;
    sem_state_t         st_q_s, st_a_s, st_b_s;
    serve_res_t         res_a_s, res_b_s, res_0_s, res_1_s;
    logic               collide_s, first1_s, evt0_s, evt1_s, ptr_d_s;
    logic [SEM_NUM-1:0] freed_s, pmid0_s, pmid1_s, pend0_d_s, pend1_d_s;

    function automatic logic [PV_W-1:0] set_pid(input logic [PV_W-1:0] pv,
                                                input logic [SEM_NUM-1:0] mask,
                                                input logic [PID_W-1:0] pid);
        logic [PV_W-1:0] r;
        r = pv;
        for (int i = 0; i < SEM_NUM; i++) begin
            if (mask[i]) begin
                r[i*PID_W +: PID_W] = pid;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rsp_word(input logic ok, input logic locked,
                                             input logic owner, input logic [PID_W-1:0] pid);
        logic [31:0] w;
        w = 32'h0000_0000;
        w[31] = ok;
        w[30] = locked;
        w[29] = owner;
        w[PID_W-1:0] = pid;
        return w;
    endfunction

    // One core's request applied to a given state; the loser of a collision sees the winner's result.
    function automatic serve_res_t serve(input logic vld, input logic core, input logic [1:0] op,
                                         input logic [IDX_W-1:0] idx, input logic [PID_W-1:0] pid,
                                         input sem_state_t st_i, output sem_state_t st_o);
        serve_res_t         res;
        logic [SEM_NUM-1:0] hit, mine, core_own;
        logic [PID_W-1:0]   cur_pid;
        logic               cur_locked, cur_owner, is_owner;
        res     = '0;
        st_o    = st_i;
        hit     = '0;
        mine    = '0;
        cur_pid = '0;
        for (int i = 0; i < SEM_NUM; i++) begin
            if (idx == IDX_W'(i)) begin
                hit[i]  = 1'b1;
                cur_pid = st_i.pidv[i*PID_W +: PID_W];
            end
        end
        core_own   = core ? st_i.own : ~st_i.own;
        cur_locked = |(st_i.lock & hit);
        cur_owner  = |(st_i.own & hit);
        is_owner   = (|(st_i.lock & core_own & hit)) && (cur_pid == pid);
        if (!vld) begin
            res = '0;
        end else if (op == 2'b11) begin
            mine      = st_i.lock & core_own;
            res.freed = mine;
            res.rsp   = rsp_word(1'b1, 1'b0, 1'b0, {PID_W{1'b0}});
            st_o.lock = st_i.lock & ~mine;
            st_o.own  = st_i.own & ~mine;
            st_o.pidv = set_pid(st_i.pidv, mine, {PID_W{1'b0}});
        end else if (hit == '0) begin
            res.err[3] = 1'b1;
        end else begin
            case (op)
                2'b00, 2'b01: begin
                    if (!cur_locked) begin
                        st_o.lock = st_i.lock | hit;
                        st_o.own  = core ? (st_i.own | hit) : (st_i.own & ~hit);
                        st_o.pidv = set_pid(st_i.pidv, hit, pid);
                        res.got   = hit;
                        res.rsp   = rsp_word(1'b1, 1'b1, core, pid);
                    end else if (is_owner) begin
                        res.got = hit;
                        res.rsp = rsp_word(1'b1, 1'b1, core, pid);
                    end else begin
                        res.fail   = hit;
                        res.err[0] = 1'b1;
                        res.rsp    = rsp_word(1'b0, 1'b1, cur_owner, cur_pid);
                    end
                end
                2'b10: begin
                    if (!cur_locked) begin
                        res.err[2] = 1'b1;
                    end else if (is_owner) begin
                        st_o.lock = st_i.lock & ~hit;
                        st_o.own  = st_i.own & ~hit;
                        st_o.pidv = set_pid(st_i.pidv, hit, {PID_W{1'b0}});
                        res.freed = hit;
                        res.rsp   = rsp_word(1'b1, 1'b0, 1'b0, {PID_W{1'b0}});
                    end else begin
                        res.err[1] = 1'b1;
                        res.rsp    = rsp_word(1'b0, 1'b1, cur_owner, cur_pid);
                    end
                end
                default: res = '0;
            endcase
        end
        return res;
    endfunction

    assign st_q_s   = {lock_r, own_r, pid_r};
    assign sem_lock = lock_r;

    // Arbitration, ordered evaluation of both cores and pending-mask bookkeeping
    always_comb begin
        st_a_s    = st_q_s;
        st_b_s    = st_q_s;
        collide_s = req_vld_0 && req_vld_1 && (req_idx_0 == req_idx_1) &&
                    (32'(req_idx_0) < 32'(SEM_NUM)) &&
                    !((req_op_0 == 2'b11) && (req_op_1 == 2'b11));
        first1_s  = collide_s & ptr_r;
        if (first1_s) begin
            res_a_s = serve(req_vld_1, 1'b1, req_op_1, req_idx_1, pid_in_1_s, st_q_s, st_a_s);
            res_b_s = serve(req_vld_0, 1'b0, req_op_0, req_idx_0, pid_in_0_s, st_a_s, st_b_s);
            res_0_s = res_b_s;
            res_1_s = res_a_s;
        end else begin
            res_a_s = serve(req_vld_0, 1'b0, req_op_0, req_idx_0, pid_in_0_s, st_q_s, st_a_s);
            res_b_s = serve(req_vld_1, 1'b1, req_op_1, req_idx_1, pid_in_1_s, st_a_s, st_b_s);
            res_0_s = res_a_s;
            res_1_s = res_b_s;
        end
        // A failure recorded this cycle still counts when the same cycle frees the semaphore
        freed_s   = res_0_s.freed | res_1_s.freed;
        pmid0_s   = pend0_r | res_0_s.fail;
        pmid1_s   = pend1_r | res_1_s.fail;
        evt0_s    = |(pmid0_s & freed_s);
        evt1_s    = |(pmid1_s & freed_s);
        pend0_d_s = pmid0_s & ~freed_s & ~res_0_s.got;
        pend1_d_s = pmid1_s & ~freed_s & ~res_1_s.got;
        ptr_d_s   = collide_s ? ~ptr_r : ptr_r;
    end

    // Lock state, pending masks, priority pointer and registered per-core responses
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            lock_r     <= '0;
            own_r      <= '0;
            pend0_r    <= '0;
            pend1_r    <= '0;
            ptr_r      <= 1'b0;
            rsp_vld_0  <= 1'b0;
            rsp_vld_1  <= 1'b0;
            rsp_data_0 <= 32'h0000_0000;
            rsp_data_1 <= 32'h0000_0000;
            semerr_0   <= '0;
            semerr_1   <= '0;
            free_evt_0 <= 1'b0;
            free_evt_1 <= 1'b0;
        end else begin
            lock_r     <= st_b_s.lock;
            own_r      <= st_b_s.own;
            pend0_r    <= pend0_d_s;
            pend1_r    <= pend1_d_s;
            ptr_r      <= ptr_d_s;
            rsp_vld_0  <= req_vld_0;
            rsp_vld_1  <= req_vld_1;
            rsp_data_0 <= res_0_s.rsp;
            rsp_data_1 <= res_1_s.rsp;
            semerr_0   <= res_0_s.err;
            semerr_1   <= res_1_s.err;
            free_evt_0 <= evt0_s;
            free_evt_1 <= evt1_s;
        end
    end

`ifdef HSEM_PROCID_EN
    assign pid_in_0_s = req_pid_0;
    assign pid_in_1_s = req_pid_1;

    // Owner pid per semaphore
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pid_r <= '0;
        end else begin
            pid_r <= st_b_s.pidv;
        end
    end
`else
    logic pid_unused_s;
    assign pid_in_0_s   = '0;
    assign pid_in_1_s   = '0;
    assign pid_r        = '0;
    assign pid_unused_s = ^{req_pid_0, req_pid_1, st_b_s.pidv};
`endif

endmodule

// File: tb/tb_hsem_lock_ctrl.sv
// Directed self-checking bench for hsem_lock_ctrl (SEM_NUM=8), with extra pid checks
// when HSEM_PROCID_EN is defined.
`timescale 1ns/1ps
module tb_hsem_lock_ctrl;
    localparam int SEM_NUM = 8;
    localparam int IDX_W   = 5;
    localparam int PID_W   = 8;
    localparam logic [1:0] OP_RL = 2'b00, OP_LK = 2'b01, OP_UL = 2'b10, OP_UA = 2'b11;

    logic              hclk = 1'b0;
    logic              hresetn;
    logic              req_vld_0, req_vld_1;
    logic [1:0]        req_op_0, req_op_1;
    logic [IDX_W-1:0]  req_idx_0, req_idx_1;
    logic [PID_W-1:0]  req_pid_0, req_pid_1;
    logic              rsp_vld_0, rsp_vld_1;
    logic [31:0]       rsp_data_0, rsp_data_1;
    logic [31:0]       semerr_0, semerr_1;
    logic              free_evt_0, free_evt_1;
    logic [SEM_NUM-1:0] sem_lock;

    int n_chk = 0;
    int n_bad = 0;

    hsem_lock_ctrl #(.SEM_NUM(SEM_NUM), .IDX_W(IDX_W), .PID_W(PID_W)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_vld_0(req_vld_0), .req_op_0(req_op_0), .req_idx_0(req_idx_0), .req_pid_0(req_pid_0),
        .req_vld_1(req_vld_1), .req_op_1(req_op_1), .req_idx_1(req_idx_1), .req_pid_1(req_pid_1),
        .rsp_vld_0(rsp_vld_0), .rsp_vld_1(rsp_vld_1),
        .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
        .semerr_0(semerr_0), .semerr_1(semerr_1),
        .free_evt_0(free_evt_0), .free_evt_1(free_evt_1),
        .sem_lock(sem_lock)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one cycle of requests; returns just after the capturing edge.
    task automatic step(input logic v0, input logic [1:0] o0, input logic [4:0] i0, input logic [7:0] p0,
                        input logic v1, input logic [1:0] o1, input logic [4:0] i1, input logic [7:0] p1);
        @(negedge hclk);
        req_vld_0 = v0; req_op_0 = o0; req_idx_0 = i0; req_pid_0 = p0;
        req_vld_1 = v1; req_op_1 = o1; req_idx_1 = i1; req_pid_1 = p1;
        @(posedge hclk);
        #1;
        req_vld_0 = 1'b0;
        req_vld_1 = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, OP_RL, 5'd0, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        hresetn = 1'b0;
        req_vld_0 = 1'b0; req_op_0 = OP_RL; req_idx_0 = '0; req_pid_0 = '0;
        req_vld_1 = 1'b0; req_op_1 = OP_RL; req_idx_1 = '0; req_pid_1 = '0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst_lock", 32'(sem_lock), 32'h0);
        chk("rst_vld0", 32'(rsp_vld_0), 32'h0);
        chk("rst_err1", semerr_1, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;

        // basic lock, contention, release with free event
        step(1'b1, OP_LK, 5'd3, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("lk3_vld", 32'(rsp_vld_0), 32'h1);
        chk("lk3_rsp", rsp_data_0, 32'hC000_0000);
        chk("lk3_map", 32'(sem_lock), 32'h08);
        chk("lk3_err", semerr_0, 32'h0);
        chk("lk3_vld1", 32'(rsp_vld_1), 32'h0);
        step(1'b0, OP_RL, 5'd0, 8'h00, 1'b1, OP_LK, 5'd3, 8'h00);
        chk("c1lk3_err", semerr_1, 32'h1);
        chk("c1lk3_rsp", rsp_data_1, 32'h4000_0000);
        step(1'b1, OP_UL, 5'd3, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("ul3_rsp", rsp_data_0, 32'h8000_0000);
        chk("ul3_map", 32'(sem_lock), 32'h00);
        chk("ul3_evt1", 32'(free_evt_1), 32'h1);
        chk("ul3_evt0", 32'(free_evt_0), 32'h0);
        idle();
        chk("ul3_evt1_end", 32'(free_evt_1), 32'h0);
        chk("idle_vld0", 32'(rsp_vld_0), 32'h0);

        // collision on idx 5, pointer toggles
        step(1'b1, OP_LK, 5'd5, 8'h00, 1'b1, OP_LK, 5'd5, 8'h00);
        chk("col1_rsp0", rsp_data_0, 32'hC000_0000);
        chk("col1_err0", semerr_0, 32'h0);
        chk("col1_rsp1", rsp_data_1, 32'h4000_0000);
        chk("col1_err1", semerr_1, 32'h1);
        chk("col1_map", 32'(sem_lock), 32'h20);
        step(1'b1, OP_UL, 5'd5, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("col1_free", 32'(free_evt_1), 32'h1);
        step(1'b1, OP_LK, 5'd5, 8'h00, 1'b1, OP_LK, 5'd5, 8'h00);
        chk("col2_rsp1", rsp_data_1, 32'hE000_0000);
        chk("col2_err0", semerr_0, 32'h1);
        chk("col2_rsp0", rsp_data_0, 32'h6000_0000);

        // unlock of free semaphore and bad index
        step(1'b1, OP_LK, 5'd9, 8'h00, 1'b1, OP_UL, 5'd2, 8'h00);
        chk("ulfree_err", semerr_1, 32'h4);
        chk("ulfree_rsp", rsp_data_1, 32'h0);
        chk("badidx_err", semerr_0, 32'h8);
        chk("badidx_map", 32'(sem_lock), 32'h20);

        // release vs relock, lock wins priority (pointer at core 0)
        step(1'b1, OP_LK, 5'd5, 8'h00, 1'b1, OP_UL, 5'd5, 8'h00);
        chk("rr1_err0", semerr_0, 32'h1);
        chk("rr1_rsp1", rsp_data_1, 32'h8000_0000);
        chk("rr1_map", 32'(sem_lock), 32'h00);
        chk("rr1_evt0", 32'(free_evt_0), 32'h1);

        // release vs relock, unlock wins priority (pointer at core 1)
        step(1'b0, OP_RL, 5'd0, 8'h00, 1'b1, OP_LK, 5'd6, 8'h00);
        chk("rr2_own", rsp_data_1, 32'hE000_0000);
        step(1'b1, OP_LK, 5'd6, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("rr2_pend", semerr_0, 32'h1);
        step(1'b1, OP_LK, 5'd6, 8'h00, 1'b1, OP_UL, 5'd6, 8'h00);
        chk("rr2_rsp0", rsp_data_0, 32'hC000_0000);
        chk("rr2_err0", semerr_0, 32'h0);
        chk("rr2_rsp1", rsp_data_1, 32'h8000_0000);
        chk("rr2_evt0", 32'(free_evt_0), 32'h1);
        chk("rr2_map", 32'(sem_lock), 32'h40);

        // read-lock, relock by owner, unlock-all-owned
        step(1'b1, OP_RL, 5'd0, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("rl0_map", 32'(sem_lock), 32'h41);
        step(1'b1, OP_LK, 5'd0, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("relk0_rsp", rsp_data_0, 32'hC000_0000);
        chk("relk0_err", semerr_0, 32'h0);
        step(1'b1, OP_LK, 5'd1, 8'h00, 1'b1, OP_LK, 5'd7, 8'h00);
        chk("ua_pre", 32'(sem_lock), 32'hC3);
        step(1'b1, OP_UA, 5'd7, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("ua_map", 32'(sem_lock), 32'h80);
        chk("ua_rsp", rsp_data_0, 32'h8000_0000);
        chk("ua_err", semerr_0, 32'h0);
        step(1'b0, OP_RL, 5'd0, 8'h00, 1'b1, OP_UL, 5'd7, 8'h00);
        chk("ul7_map", 32'(sem_lock), 32'h00);

        // unlock by non-owner
        step(1'b0, OP_RL, 5'd0, 8'h00, 1'b1, OP_LK, 5'd2, 8'h00);
        step(1'b1, OP_UL, 5'd2, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("nown_err", semerr_0, 32'h2);
        chk("nown_rsp", rsp_data_0, 32'h6000_0000);
        chk("nown_map", 32'(sem_lock), 32'h04);

        // reset in the middle of activity
        step(1'b1, OP_LK, 5'd4, 8'h00, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("mid_map", 32'(sem_lock), 32'h14);
        hresetn = 1'b0;
        #1;
        chk("mid_rst_map", 32'(sem_lock), 32'h0);
        chk("mid_rst_vld", 32'(rsp_vld_0), 32'h0);
        chk("mid_rst_rsp", rsp_data_0, 32'h0);
        @(negedge hclk);
        hresetn = 1'b1;
        idle();
        chk("post_rst_evt", 32'({free_evt_0, free_evt_1}), 32'h0);
        chk("post_rst_err", semerr_0 | semerr_1, 32'h0);

        // pid ownership
        step(1'b1, OP_LK, 5'd4, 8'h11, 1'b0, OP_RL, 5'd0, 8'h00);
`ifdef HSEM_PROCID_EN
        chk("pid_lk_rsp", rsp_data_0, 32'hC000_0011);
        step(1'b1, OP_UL, 5'd4, 8'h22, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("pid_ul_err", semerr_0, 32'h2);
        chk("pid_ul_rsp", rsp_data_0, 32'h4000_0011);
        chk("pid_ul_map", 32'(sem_lock), 32'h10);
`else
        chk("pid_lk_rsp", rsp_data_0, 32'hC000_0000);
        step(1'b1, OP_UL, 5'd4, 8'h22, 1'b0, OP_RL, 5'd0, 8'h00);
        chk("pid_ul_err", semerr_0, 32'h0);
        chk("pid_ul_rsp", rsp_data_0, 32'h8000_0000);
        chk("pid_ul_map", 32'(sem_lock), 32'h00);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
